// File: rtl/auto_scale_ctrl_pkg.sv
// auto_scale_ctrl_pkg: shared constants, fit bounds and FSM state type for the auto scale controller
package auto_scale_ctrl_pkg;
    localparam int SAMPLE_CENTER = 127;
    localparam int SCALE_W       = 3;
    localparam int UNITY_SCALE   = 4;
    localparam int FIT_W         = 14;
    localparam logic signed [FIT_W-1:0] FIT_HI = 14'sd127;
    localparam logic signed [FIT_W-1:0] FIT_LO = -14'sd128;
    typedef enum logic [1:0] {IDLE, EVAL, DECIDE} state_e;
endpackage

// File: rtl/scale_fit_check.sv
// scale_fit_check: combinational in_range test of a deviation envelope at a candidate scale
module scale_fit_check
    import auto_scale_ctrl_pkg::*;
(
    input  logic signed [8:0]         i_pmax,
    input  logic signed [8:0]         i_nmin,
    input  logic        [SCALE_W-1:0] i_scale,
    output logic                      o_fits
);
    logic                      w_up;
    logic        [SCALE_W-1:0] w_sh;
    logic signed [FIT_W-1:0]   w_pe;
    logic signed [FIT_W-1:0]   w_ne;
    logic signed [FIT_W-1:0]   w_p;
    logic signed [FIT_W-1:0]   w_n;
    // gain = 2^(UNITY-scale): left shift at or below unity, arithmetic right shift above it
    always_comb begin
        w_up   = i_scale <= SCALE_W'(UNITY_SCALE);
        w_sh   = w_up ? SCALE_W'(UNITY_SCALE) - i_scale : i_scale - SCALE_W'(UNITY_SCALE);
        w_pe   = i_pmax;
        w_ne   = i_nmin;
        w_p    = w_up ? w_pe <<< w_sh : w_pe >>> w_sh;
        w_n    = w_up ? w_ne <<< w_sh : w_ne >>> w_sh;
        o_fits = (w_p <= FIT_HI) && (w_n >= FIT_LO);
    end
endmodule

// File: rtl/auto_scale_ctrl.sv
// auto_scale_ctrl: per-frame deviation tracking and scale selection with hysteresis on gain increases
module auto_scale_ctrl
    import auto_scale_ctrl_pkg::*;
#(
    parameter int MIN_SCALE     = 0,
    parameter int MAX_SCALE     = 7,
    parameter int DEFAULT_SCALE = 4,
    parameter int HOLD_FRAMES   = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [7:0]         sample_in,
    input  logic               frame_end,
    input  logic               auto_en,
    input  logic [SCALE_W-1:0] manual_scale,
    output logic [SCALE_W-1:0] scale_out,
    output logic               scale_update,
    output logic               busy
);
    state_e                    r_state;
    logic signed [8:0]         r_pmax;
    logic signed [8:0]         r_nmin;
    logic                      r_have;
    logic signed [8:0]         r_eval_pmax;
    logic signed [8:0]         r_eval_nmin;
    logic        [SCALE_W-1:0] r_cand;
    logic        [SCALE_W-1:0] r_target;
    logic        [3:0]         r_hold;
    logic        [SCALE_W-1:0] r_scale;
    logic                      r_upd;
    logic signed [8:0]         w_d;
    logic signed [8:0]         w_pmax_nx;
    logic signed [8:0]         w_nmin_nx;
    logic                      w_start;
    logic                      w_fits;
    logic                      w_decide;
    logic                      w_apply;

    scale_fit_check u_fit (
        .i_pmax  (r_eval_pmax),
        .i_nmin  (r_eval_nmin),
        .i_scale (r_cand),
        .o_fits  (w_fits)
    );

    // running envelope including this cycle's sample; a start needs at least one sample in the frame
    always_comb begin
        w_d       = $signed({1'b0, sample_in}) - 9'sd127;
        w_pmax_nx = (sample_valid && w_d > r_pmax) ? w_d : r_pmax;
        w_nmin_nx = (sample_valid && w_d < r_nmin) ? w_d : r_nmin;
        w_start   = frame_end && r_state == IDLE && (r_have || sample_valid);
        w_decide  = r_state == DECIDE && auto_en;
        w_apply   = w_decide && (r_target > r_scale ||
                    (r_target < r_scale && r_hold == 4'(HOLD_FRAMES - 1)));
    end

    // accumulate every cycle; on an accepted frame_end snapshot for evaluation and restart
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pmax      <= '0;
            r_nmin      <= '0;
            r_have      <= 1'b0;
            r_eval_pmax <= '0;
            r_eval_nmin <= '0;
        end else if (w_start) begin
            r_pmax      <= '0;
            r_nmin      <= '0;
            r_have      <= 1'b0;
            r_eval_pmax <= w_pmax_nx;
            r_eval_nmin <= w_nmin_nx;
        end else begin
            r_pmax      <= w_pmax_nx;
            r_nmin      <= w_nmin_nx;
            r_have      <= r_have | sample_valid;
        end
    end

    // candidate search from highest gain down, then a one-cycle decision with hold counting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cand   <= SCALE_W'(MIN_SCALE);
            r_target <= SCALE_W'(DEFAULT_SCALE);
            r_hold   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= w_start ? EVAL : IDLE;
                    r_cand  <= SCALE_W'(MIN_SCALE);
                end
                EVAL: begin
                    r_state  <= (w_fits || r_cand == SCALE_W'(MAX_SCALE)) ? DECIDE : EVAL;
                    r_target <= r_cand;
                    r_cand   <= r_cand + 1'b1;
                end
                DECIDE: begin
                    r_state <= IDLE;
                    r_hold  <= (!auto_en || w_apply || r_target >= r_scale) ? 4'd0 : r_hold + 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // manual mode tracks manual_scale every cycle; auto mode writes only on an applied decision
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scale <= SCALE_W'(DEFAULT_SCALE);
            r_upd   <= 1'b0;
        end else if (!auto_en) begin
            r_scale <= manual_scale;
            r_upd   <= manual_scale != r_scale;
        end else begin
            r_scale <= w_apply ? r_target : r_scale;
            r_upd   <= w_apply;
        end
    end

    assign scale_out    = r_scale;
    assign scale_update = r_upd;
    assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_auto_scale_ctrl.sv
// tb_auto_scale_ctrl: table-driven frames with a scoreboard of expected decisions plus hand-written corner sequences
module tb_auto_scale_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = 8'd127;
    logic       frame_end = 1'b0;
    logic       auto_en = 1'b1;
    logic [2:0] manual_scale = 3'd0;
    logic [2:0] scale_out;
    logic       scale_update;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [7:0] v;
        int         n;
        bit         fe_v;
        logic [7:0] fe_s;
        bit         inj;
        bit         eb;
        int         es;
        bit         eu;
        int         lat;
    } vec_t;

    typedef struct {
        int scale;
        bit upd;
        bit bsy;
    } exp_t;

    vec_t tbl[18];
    exp_t q[$];

    auto_scale_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .frame_end    (frame_end),
        .auto_en      (auto_en),
        .manual_scale (manual_scale),
        .scale_out    (scale_out),
        .scale_update (scale_update),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run_frame(input vec_t t);
        int   bcnt = 0;
        int   ucnt = 0;
        int   first_upd = -1;
        bit   seen = 1'b0;
        bit   done = 1'b0;
        exp_t e;
        for (int i = 0; i < t.n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = t.v;
        end
        @(negedge clk);
        sample_valid = t.fe_v;
        sample_in    = t.fe_s;
        frame_end    = 1'b1;
        q.push_back('{scale: t.es, upd: t.eu, bsy: t.eb});
        @(negedge clk);
        frame_end    = 1'b0;
        sample_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (busy) begin
                bcnt++;
                seen = 1'b1;
            end
            if (scale_update) begin
                ucnt++;
                if (first_upd < 0) first_upd = c;
            end
            if ((seen && !busy) || (!t.eb && c >= 10)) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            sample_valid = t.inj && c == 1;
            frame_end    = t.inj && c == 1;
            sample_in    = 8'd255;
        end
        frame_end    = 1'b0;
        sample_valid = 1'b0;
        if (!done) chk({t.nm, "_timeout"}, 0, 1);
        if (q.size() == 0) begin
            chk({t.nm, "_queue"}, 0, 1);
        end else begin
            e = q.pop_front();
            chk({t.nm, "_busy"}, int'(seen), int'(e.bsy));
            chk({t.nm, "_scale"}, int'(scale_out), e.scale);
            chk({t.nm, "_upd"}, ucnt, int'(e.upd));
        end
        if (t.lat > 0) begin
            chk({t.nm, "_latency"}, first_upd, t.lat);
            chk({t.nm, "_busycyc"}, bcnt, t.lat - 1);
        end
    endtask

    initial begin
        tbl[0]  = '{"big255",   8'd255, 16, 0, 8'd0,   0, 1, 5, 1, 8};
        tbl[1]  = '{"quiet1",   8'd127,  8, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[2]  = '{"quiet2",   8'd127,  8, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[3]  = '{"loud_clr", 8'd255,  4, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[4]  = '{"quiet3",   8'd127,  8, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[5]  = '{"quiet4",   8'd127,  8, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[6]  = '{"quiet5",   8'd127,  8, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[7]  = '{"quiet6",   8'd127,  8, 0, 8'd0,   0, 1, 0, 1, 0};
        tbl[8]  = '{"pos8",     8'd135,  6, 0, 8'd0,   0, 1, 1, 1, 0};
        tbl[9]  = '{"neg127",   8'd0,    6, 0, 8'd0,   0, 1, 4, 1, 0};
        tbl[10] = '{"neg8_a",   8'd119,  6, 0, 8'd0,   0, 1, 4, 0, 0};
        tbl[11] = '{"neg8_b",   8'd119,  6, 0, 8'd0,   0, 1, 4, 0, 0};
        tbl[12] = '{"empty",    8'd0,    0, 0, 8'd0,   0, 0, 4, 0, 0};
        tbl[13] = '{"neg8_c",   8'd119,  6, 0, 8'd0,   0, 1, 4, 0, 0};
        tbl[14] = '{"neg8_d",   8'd119,  6, 0, 8'd0,   0, 1, 0, 1, 0};
        tbl[15] = '{"same_cyc", 8'd127,  4, 1, 8'd255, 1, 1, 5, 1, 0};
        tbl[16] = '{"rollover", 8'd0,    0, 0, 8'd0,   0, 1, 5, 0, 0};
        tbl[17] = '{"man_eval", 8'd255,  4, 0, 8'd0,   0, 1, 6, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_scale", int'(scale_out), 4);
        chk("rst_upd", int'(scale_update), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) run_frame(tbl[i]);

        @(negedge clk);
        auto_en      = 1'b0;
        manual_scale = 3'd2;
        @(negedge clk);
        chk("man2_scale", int'(scale_out), 2);
        chk("man2_upd", int'(scale_update), 1);
        @(negedge clk);
        chk("man2_hold_upd", int'(scale_update), 0);
        manual_scale = 3'd6;
        @(negedge clk);
        chk("man6_scale", int'(scale_out), 6);
        chk("man6_upd", int'(scale_update), 1);
        run_frame(tbl[17]);

        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = 8'd0;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        frame_end    = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        @(negedge clk);
        chk("eval_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_scale", int'(scale_out), 4);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_upd", int'(scale_update), 0);
        @(negedge clk);
        chk("midrst_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
